add_sub_resp_checker: RTL

//  Response-side companion to the 4-bit adder/subtractor stimulus sweep. Accepts
//  {mode,a,b} vectors plus the DUT result over a valid/ready handshake, computes
//  the golden result, compares one cycle later, and keeps pass/fail counts plus
//  a snapshot of the first mismatch. Synthesizable; usable on-chip as BIST sink.

---
 rtl/add_sub_resp_checker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/add_sub_resp_checker.sv
// Response checker for the 4-bit adder/subtractor sweep.
// It accepts {mode,a,b,res} over a valid/ready handshake and computes the golden
// result. One edge later it compares that result against res. It keeps saturating
// pass/fail counts and a snapshot of the first mismatch in each run.
module add_sub_resp_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NUM_VECTORS = 512,
    parameter int unsigned CNT_W       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH:0]     res,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               fail_seen,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [WIDTH:0]     first_fail_exp,
    output logic [WIDTH:0]     first_fail_got,
    output logic               busy,
    output logic               done
);

    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic             drain_q;
    logic [CNT_W-1:0] idx_q;

    logic             s1_vld_q;
    logic [CNT_W-1:0] s1_idx_q;
    logic [RW-1:0]    s1_exp_q;
    logic [RW-1:0]    s1_res_q;

    logic             xfer_d;
    logic             start_clr_d;
    logic             last_d;
    logic             mismatch_d;
    logic [RW-1:0]    exp_d;

    // Handshake, golden result and compare decode
    always_comb begin
        xfer_d      = in_valid && in_ready;
        start_clr_d = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_d      = (idx_q == CNT_W'(NUM_VECTORS - 1));
        mismatch_d  = (s1_exp_q != s1_res_q);
        if (mode) begin
            exp_d = {1'b0, a} + {1'b0, ~b} + RW'(1);
        end else begin
            exp_d = {1'b0, a} + {1'b0, b};
        end
    end

    // Run-control FSM with registered ready/busy/done and the vector index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            drain_q  <= 1'b0;
            idx_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        idx_q    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (xfer_d) begin
                        idx_q <= idx_q + CNT_W'(1);
                        if (last_d) begin
                            state_q  <= S_DRAIN;
                            drain_q  <= 1'b0;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q <= S_DONE;
                        drain_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture index, golden and DUT result at each transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_exp_q <= '0;
            s1_res_q <= '0;
        end else begin
            s1_vld_q <= xfer_d;
            if (xfer_d) begin
                s1_idx_q <= idx_q;
                s1_exp_q <= exp_d;
                s1_res_q <= res;
            end
        end
    end

    // Stage 2: saturating counters and first-mismatch snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (start_clr_d) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (s1_vld_q) begin
            if (!mismatch_d) begin
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end else begin
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                if (!fail_seen) begin
                    fail_seen      <= 1'b1;
                    first_fail_idx <= s1_idx_q;
                    first_fail_exp <= s1_exp_q;
                    first_fail_got <= s1_res_q;
                end
            end
        end
    end

endmodule
